// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file writeback arbiter: entry layout and
// round-robin pointer encoding.
package regfile_wb_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        LAST0 = 1'b0,
        LAST1 = 1'b1
    } arb_state_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// DEPTH-entry synchronous FIFO of writeback entries. With WB_PENDING_MASK_EN
// defined it also exposes its storage and per-slot occupancy.
import regfile_wb_pkg::*;

module wb_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   push,
    input  wb_entry_t              push_data,
    input  logic                   pop,
    output wb_entry_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
`ifdef WB_PENDING_MASK_EN
   ,output wb_entry_t              entries [DEPTH]
   ,output logic [DEPTH-1:0]       occ
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count and pointers define
    // validity, so stale contents are never observed.
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

`ifdef WB_PENDING_MASK_EN
    assign entries = mem;

    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] off;
            off    = PW'(i) - rd_ptr;
            occ[i] = ({1'b0, off} < count);
        end
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU
// and load writeback sources. Optional Pending_Mask output: WB_PENDING_MASK_EN.
import regfile_wb_pkg::*;

module regfile_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          Req0_Valid,
    output logic          Req0_Ready,
    input  logic [AW-1:0] Req0_Addr,
    input  logic [DW-1:0] Req0_Data,
    input  logic          Req1_Valid,
    output logic          Req1_Ready,
    input  logic [AW-1:0] Req1_Addr,
    input  logic [DW-1:0] Req1_Data,
    output logic          Write_Reg,
    output logic [AW-1:0] W_Addr,
    output logic [DW-1:0] W_Data,
    output logic          Idle
`ifdef WB_PENDING_MASK_EN
   ,output logic [31:0]   Pending_Mask
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t       in0, in1, head0, head1, gnt_entry;
    logic            full0, full1, empty0, empty1;
    logic [CW-1:0]   count0, count1;
    logic            grant_valid, grant_src;
    arb_state_t      state, state_next;

    assign in0 = '{addr: Req0_Addr, data: Req0_Data};
    assign in1 = '{addr: Req1_Addr, data: Req1_Data};

`ifdef WB_PENDING_MASK_EN
    wb_entry_t        ent0 [DEPTH];
    wb_entry_t        ent1 [DEPTH];
    logic [DEPTH-1:0] occ0, occ1;
`endif

    wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .CLK(CLK), .RST(RST),
        .push(Req0_Valid), .push_data(in0),
        .pop(grant_valid && !grant_src), .head(head0),
        .full(full0), .empty(empty0), .count(count0)
`ifdef WB_PENDING_MASK_EN
       ,.entries(ent0), .occ(occ0)
`endif
    );

    wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .CLK(CLK), .RST(RST),
        .push(Req1_Valid), .push_data(in1),
        .pop(grant_valid && grant_src), .head(head1),
        .full(full1), .empty(empty1), .count(count1)
`ifdef WB_PENDING_MASK_EN
       ,.entries(ent1), .occ(occ1)
`endif
    );

    assign Req0_Ready = !full0;
    assign Req1_Ready = !full1;
    assign Idle       = (count0 == '0) && (count1 == '0) && !Write_Reg;

    // NOTE: every combinational output gets a default first, so no path
    // through the if-chain can leave a latch behind.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = 1'b0;
        state_next  = state;
        if (!empty0 && !empty1) begin
            grant_valid = 1'b1;
            grant_src   = (state == LAST0);
        end else if (!empty0) begin
            grant_valid = 1'b1;
            grant_src   = 1'b0;
        end else if (!empty1) begin
            grant_valid = 1'b1;
            grant_src   = 1'b1;
        end
        if (grant_valid) state_next = grant_src ? LAST1 : LAST0;
    end

    assign gnt_entry = grant_src ? head1 : head0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= LAST1;
            Write_Reg <= 1'b0;
            W_Addr    <= '0;
            W_Data    <= '0;
        end else begin
            state <= state_next;
            if (grant_valid) begin
                // Writes to r0 are consumed but never reach the register file.
                Write_Reg <= (gnt_entry.addr != '0);
                W_Addr    <= gnt_entry.addr;
                W_Data    <= gnt_entry.data;
            end else begin
                Write_Reg <= 1'b0;
            end
        end
    end

`ifdef WB_PENDING_MASK_EN
    always_comb begin
        Pending_Mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ0[i]) Pending_Mask[ent0[i].addr] = 1'b1;
            if (occ1[i]) Pending_Mask[ent1[i].addr] = 1'b1;
        end
        if (Write_Reg) Pending_Mask[W_Addr] = 1'b1;
        Pending_Mask[0] = 1'b0;
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, scoreboard-checked bench for regfile_wb_arbiter; the Pending_Mask
// checks are built only when WB_PENDING_MASK_EN is defined.
import regfile_wb_pkg::*;

module tb_regfile_wb_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        Req0_Valid = 1'b0, Req1_Valid = 1'b0;
    logic        Req0_Ready, Req1_Ready;
    logic [4:0]  Req0_Addr = '0, Req1_Addr = '0;
    logic [31:0] Req0_Data = '0, Req1_Data = '0;
    logic        Write_Reg;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;
    logic        Idle;
`ifdef WB_PENDING_MASK_EN
    logic [31:0] Pending_Mask;
`endif

    int        n_checks = 0;
    int        n_errors = 0;
    wb_entry_t sb_q [$];

    regfile_wb_arbiter dut (
        .CLK(CLK), .RST(RST),
        .Req0_Valid(Req0_Valid), .Req0_Ready(Req0_Ready),
        .Req0_Addr(Req0_Addr), .Req0_Data(Req0_Data),
        .Req1_Valid(Req1_Valid), .Req1_Ready(Req1_Ready),
        .Req1_Addr(Req1_Addr), .Req1_Data(Req1_Data),
        .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data),
        .Idle(Idle)
`ifdef WB_PENDING_MASK_EN
       ,.Pending_Mask(Pending_Mask)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wb_entry_t e;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of requests; acc reports whether each handshake fired.
    task automatic cycle(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         output logic acc0, output logic acc1);
        Req0_Valid = v0; Req0_Addr = a0; Req0_Data = d0;
        Req1_Valid = v1; Req1_Addr = a1; Req1_Data = d1;
        acc0 = v0 && Req0_Ready;
        acc1 = v1 && Req1_Ready;
        step();
        Req0_Valid = 1'b0;
        Req1_Valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((sb_q.size() != 0 || !Idle) && n < budget) begin
            step();
            n++;
        end
        check(tag, 64'(sb_q.size() == 0 && Idle), 64'(1));
    endtask

    // Register file samples on negedge; every issued write must match the scoreboard head.
    always @(negedge CLK) begin
        if (!RST && Write_Reg) begin
            check("sb_has_expected", 64'(sb_q.size() != 0), 64'(1));
            if (sb_q.size() != 0) begin
                wb_entry_t e;
                e = sb_q.pop_front();
                check("wr_addr", 64'(W_Addr), 64'(e.addr));
                check("wr_data", 64'(W_Data), 64'(e.data));
            end
        end
    end

    initial begin
        logic a0, a1;
        int   i0, i1;

        // Reset values
        #1 RST = 1'b1;
        #2;
        check("rst_write_reg", 64'(Write_Reg), 64'(0));
        check("rst_w_addr", 64'(W_Addr), 64'(0));
        check("rst_w_data", 64'(W_Data), 64'(0));
        check("rst_idle", 64'(Idle), 64'(1));
        check("rst_ready0", 64'(Req0_Ready), 64'(1));
        check("rst_ready1", 64'(Req1_Ready), 64'(1));
        step();
        step();
        RST = 1'b0;

        // Single source, one-cycle latency
        expect_wr(5'd3, 32'hDEADBEEF);
        cycle(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, a0, a1);
        check("single_accept", 64'(a0), 64'(1));
        check("single_not_yet", 64'(Write_Reg), 64'(0));
        step();
        check("single_we", 64'(Write_Reg), 64'(1));
        check("single_addr", 64'(W_Addr), 64'(3));
        check("single_data", 64'(W_Data), 64'(32'hDEADBEEF));
        step();
        check("single_we_drop", 64'(Write_Reg), 64'(0));
        check("single_idle", 64'(Idle), 64'(1));

        // Mid-cycle reset while a write is on the port and an entry is queued
        cycle(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0, a0, a1);
        cycle(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0, a0, a1);
        check("pre_rst_we", 64'(Write_Reg), 64'(1));
        check("pre_rst_addr", 64'(W_Addr), 64'(5));
        #2 RST = 1'b1;
        #1;
        check("async_rst_we", 64'(Write_Reg), 64'(0));
        check("async_rst_addr", 64'(W_Addr), 64'(0));
        check("async_rst_idle", 64'(Idle), 64'(1));
        check("async_rst_ready0", 64'(Req0_Ready), 64'(1));
        check("async_rst_ready1", 64'(Req1_Ready), 64'(1));
        step();
        RST = 1'b0;
        step();
        step();
        check("rst_discarded_we", 64'(Write_Reg), 64'(0));
        check("rst_discarded_idle", 64'(Idle), 64'(1));

        // Contention: src0 pushes odd addresses, src1 even; grants alternate 0,1,...
        for (int k = 1; k <= 8; k++) expect_wr(5'(k), 32'hC0DE0000 | 32'(k));
        i0 = 0;
        i1 = 0;
        for (int c = 0; c < 40 && (i0 < 4 || i1 < 4); c++) begin
            cycle(i0 < 4, 5'(2 * i0 + 1), 32'hC0DE0000 | 32'(2 * i0 + 1),
                  i1 < 4, 5'(2 * i1 + 2), 32'hC0DE0000 | 32'(2 * i1 + 2), a0, a1);
            if (a0) i0++;
            if (a1) i1++;
        end
        check("cont_src0_pushed", 64'(i0), 64'(4));
        check("cont_src1_pushed", 64'(i1), 64'(4));
        wait_drain("cont_drain", 30);

        // Backpressure: src0 wins the first contention so src1 fills up
        expect_wr(5'd9, 32'h900);
        expect_wr(5'd10, 32'hA01);
        expect_wr(5'd11, 32'hB02);
        expect_wr(5'd12, 32'hC03);
        cycle(1'b1, 5'd9, 32'h900, 1'b1, 5'd10, 32'hA01, a0, a1);
        check("bp_push1", 64'(a1), 64'(1));
        check("bp_ready_after1", 64'(Req1_Ready), 64'(1));
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'hB02, a0, a1);
        check("bp_push2", 64'(a1), 64'(1));
        check("bp_full_ready", 64'(Req1_Ready), 64'(0));
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC03, a0, a1);
        check("bp_third_blocked", 64'(a1), 64'(0));
        check("bp_ready_after_pop", 64'(Req1_Ready), 64'(1));
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC03, a0, a1);
        check("bp_third_accepted", 64'(a1), 64'(1));
        wait_drain("bp_drain", 20);

        // Address-0 entry is consumed and dropped
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h12345678, a0, a1);
        check("r0_accept", 64'(a1), 64'(1));
        step();
        check("r0_we", 64'(Write_Reg), 64'(0));
        check("r0_addr", 64'(W_Addr), 64'(0));
        check("r0_data", 64'(W_Data), 64'(32'h12345678));
        check("r0_idle", 64'(Idle), 64'(1));
`ifdef WB_PENDING_MASK_EN
        check("r0_mask0", 64'(Pending_Mask[0]), 64'(0));
`endif

        // Same destination from both sources right after reset
        RST = 1'b1;
        step();
        RST = 1'b0;
        expect_wr(5'd7, 32'hA);
        expect_wr(5'd7, 32'hB);
        cycle(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, a0, a1);
        check("same_accept", 64'({a0, a1}), 64'(2'b11));
`ifdef WB_PENDING_MASK_EN
        check("same_mask_queued", 64'(Pending_Mask), 64'(32'h80));
`endif
        step();
        check("same_first_we", 64'(Write_Reg), 64'(1));
        check("same_first_data", 64'(W_Data), 64'(32'hA));
`ifdef WB_PENDING_MASK_EN
        check("same_mask_first", 64'(Pending_Mask[7]), 64'(1));
`endif
        step();
        check("same_second_we", 64'(Write_Reg), 64'(1));
        check("same_second_data", 64'(W_Data), 64'(32'hB));
`ifdef WB_PENDING_MASK_EN
        check("same_mask_second", 64'(Pending_Mask[7]), 64'(1));
`endif
        step();
        check("same_done_we", 64'(Write_Reg), 64'(0));
        check("same_done_idle", 64'(Idle), 64'(1));
`ifdef WB_PENDING_MASK_EN
        check("same_mask_clear", 64'(Pending_Mask), 64'(0));
`endif
        check("sb_empty_at_end", 64'(sb_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback sources: requester 0 (ALU result) and requester 1 (memory load).
- Each source pushes {addr, data} through a valid/ready handshake into its own small FIFO.
- A round-robin scheduler drains one entry per cycle onto the register file write port (Write_Reg, W_Addr, W_Data).
- Sits between the execute/memory stages and the register file.

Parameters:
- DEPTH, 2, entries per source FIFO (power of 2, >=2).
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- CLK  input  1  clock; all block state updates on posedge CLK.
- RST  input  1  asynchronous reset, active-high.
- Req0_Valid  input  1  source 0 has a write.
- Req0_Ready  output  1  source 0 FIFO not full.
- Req0_Addr  input  AW  source 0 destination register.
- Req0_Data  input  DW  source 0 write data.
- Req1_Valid / Req1_Ready / Req1_Addr / Req1_Data: same as source 0, for source 1.
- Write_Reg  output  1  register file write enable.
- W_Addr  output  AW  register file write address.
- W_Data  output  DW  register file write data.
- Idle  output  1  both FIFOs empty and no write issuing this cycle.

Behaviour:
- Reset (async, immediate): FIFOs emptied; Write_Reg=0, W_Addr=0, W_Data=0; last-grant pointer=1, so source 0 wins the first contention; Req*_Ready=1; Idle=1.
- Push: accepted on posedge CLK when Reqn_Valid && Reqn_Ready.
  - Reqn_Ready = !full(n), combinational from FIFO count only.
  - No pass-through when full: a push and a pop in the same cycle on a full FIFO are not both possible because Ready is already 0.
- Latency: an entry pushed at edge k can be granted at edge k+1, so W_* is valid after edge k+1. Minimum push-to-Write_Reg latency is 1 cycle.
  - The register file samples on negedge, half a cycle after W_* changes.
- Arbiter states: LAST0, LAST1 (pointer to the last-granted source).
  - Only one head non-empty: grant it; pointer moves to that source.
  - Both non-empty: grant the source that is not the pointer; pointer toggles.
  - Neither non-empty: no grant; pointer holds.
- Outputs registered: on grant, W_Addr/W_Data <= head entry, and the entry is popped.
  - Write_Reg <= 1 only if the head address != 0.
  - An address-0 entry is popped and silently dropped: Write_Reg <= 0, and W_Addr/W_Data are still updated.
  - No grant: Write_Reg <= 0; W_Addr/W_Data hold their values.
- Ordering:
  - Strict FIFO order within each source.
  - Between sources, order follows grant order.
  - Both heads targeting the same register in the same cycle: the round-robin winner writes first; the loser writes in the following cycle and is the final value.
- Throughput: one write per cycle. With both sources continuously valid, each gets 50% of the write bandwidth.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Reset asserted mid-operation: pending entries are discarded; Write_Reg drops to 0 asynchronously.

Optional Feature:
- Macro WB_PENDING_MASK_EN.
- Defined: adds output Pending_Mask [31:0].
  - Bit r=1 if any entry in either FIFO, or the write currently on W_* with Write_Reg=1, targets register r != 0.
  - Bit 0 is always 0.
  - Combinational from FIFO contents plus output register; for hazard stall logic.
- Not defined: port absent; no comparators synthesized.

Decomposition:
- Package regfile_wb_pkg: AW/DW defaults, the wb_entry_t struct {addr, data}, and the LAST0/LAST1 state encoding.
- One sub-module, wb_fifo: DEPTH-entry synchronous FIFO of wb_entry_t with push/pop/full/empty/count and the same CLK/RST. It is instantiated twice.
- Arbiter and output register stay in the top level.

Test Plan:
- Reset: assert RST mid-cycle while Write_Reg=1 -> Write_Reg=0 and W_Addr=0 immediately, Idle=1, both Ready=1.
- Single source: Req0 pushes {3, 0xDEADBEEF} at edge 1 -> at edge 2 Write_Reg=1, W_Addr=3, W_Data=0xDEADBEEF; at edge 3 Write_Reg=0.
- Contention: both sources valid every cycle with distinct addresses 1..8 -> grants alternate 0,1,0,1; no entry lost; each source's addresses appear in push order.
- Full/backpressure: hold source 1 granted-out by keeping source 0 busy, push 2 entries to source 1 -> Req1_Ready=0 after the second push; a third Valid is not accepted until a pop.
- R0 drop: Req1 pushes {0, 0x12345678} -> entry consumed, Write_Reg stays 0, W_Addr=0, W_Data=0x12345678; Pending_Mask[0]=0 if enabled.
- Same address: both push {7, 0xA} (src0) and {7, 0xB} (src1) in the same cycle after reset -> write 0xA then 0xB to r7 on consecutive cycles; with WB_PENDING_MASK_EN, Pending_Mask[7]=1 until the cycle after the 0xB write.
